// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and the sync bus carried through the alignment delay.
// The 800x600 set is meant to be passed as parameter overrides to vga_timing_gen.
package vga_timing_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam logic        VGA_H_POL    = 1'b0;
    localparam logic        VGA_V_POL    = 1'b0;

    localparam int unsigned SVGA_H_ACTIVE = 800;
    localparam int unsigned SVGA_H_FP     = 40;
    localparam int unsigned SVGA_H_SYNC   = 128;
    localparam int unsigned SVGA_H_BP     = 88;
    localparam int unsigned SVGA_V_ACTIVE = 600;
    localparam int unsigned SVGA_V_FP     = 1;
    localparam int unsigned SVGA_V_SYNC   = 4;
    localparam int unsigned SVGA_V_BP     = 23;
    localparam logic        SVGA_H_POL    = 1'b1;
    localparam logic        SVGA_V_POL    = 1'b1;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } sync_bus_t;

    // Output level of a sync: raw XNOR polarity (pol=0 gives active-low).
    function automatic logic sync_level(input logic raw, input logic pol);
        return raw ~^ pol;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// DEPTH-stage shift register that aligns {hsync, vsync, de} with fetched pixel data.
// Flush loads FLUSH_VAL into every stage so no stale sync survives a restart.
module vga_sync_delay
    import vga_timing_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter sync_bus_t   FLUSH_VAL = '0
) (
    input  logic      clk,
    input  logic      en,
    input  logic      flush,
    input  sync_bus_t din,
    output sync_bus_t dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, en, flush};
            assign dout        = din;
        end else begin : g_shift
            sync_bus_t stages [DEPTH];

            always_ff @(posedge clk) begin
                if (flush) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        stages[i] <= FLUSH_VAL;
                    end
                end else if (en) begin
                    stages[0] <= din;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        stages[i] <= stages[i-1];
                    end
                end
            end

            assign dout = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, registered position, syncs,
// data enable aligned to a PIPE_DLY-pixel fetch pipeline, line interrupt and frame count.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter logic        H_POL    = VGA_H_POL,
    parameter logic        V_POL    = VGA_V_POL,
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 10,
    parameter int unsigned PIPE_DLY = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pix_en,
    input  logic           run,
    input  logic [Y_W-1:0] line_cmp,
    output logic [X_W-1:0] posx,
    output logic [Y_W-1:0] posy,
    output logic           active,
    output logic           h_sync_o,
    output logic           v_sync_o,
    output logic           de_o,
    output logic           line_start,
    output logic           frame_start,
    output logic           line_irq,
    output logic [15:0]    frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HC_W    = $clog2(H_TOTAL + 1);
    localparam int unsigned VC_W    = $clog2(V_TOTAL + 1);

    localparam logic [HC_W-1:0] H_ACT_C  = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0] HS_BEG_C = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0] HS_END_C = HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HC_W-1:0] H_LAST_C = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0] V_ACT_C  = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0] VS_BEG_C = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0] VS_END_C = VC_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VC_W-1:0] V_LAST_C = VC_W'(V_TOTAL - 1);

    logic [HC_W-1:0] h_cnt;
    logic [VC_W-1:0] v_cnt;
    logic [15:0]     frame_q;
    logic            hs_lvl;
    logic            vs_lvl;
    logic            h_vis;
    logic            v_vis;
    logic            hs_raw;
    logic            vs_raw;
    logic            h_zero;
    logic            v_zero;
    logic            cmp_hit;
    sync_bus_t       pipe_in;
    sync_bus_t       pipe_out;

    always_comb begin
        h_vis   = h_cnt < H_ACT_C;
        v_vis   = v_cnt < V_ACT_C;
        hs_raw  = (h_cnt >= HS_BEG_C) && (h_cnt < HS_END_C);
        vs_raw  = (v_cnt >= VS_BEG_C) && (v_cnt < VS_END_C);
        h_zero  = h_cnt == '0;
        v_zero  = v_cnt == '0;
        // v_cnt never reaches V_TOTAL, so an out-of-range line_cmp can never match
        cmp_hit = 32'(line_cmp) == 32'(v_cnt);
    end

    // frame_cnt advances on the enabled cycle after frame_start is shown; a pulse
    // still showing when run drops is counted before it is cleared.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            posx        <= '0;
            posy        <= '0;
            active      <= 1'b0;
            hs_lvl      <= ~H_POL;
            vs_lvl      <= ~V_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            line_irq    <= 1'b0;
            frame_q     <= rst ? '0 : frame_q + 16'(frame_start);
        end else if (pix_en) begin
            posx        <= h_vis ? X_W'(h_cnt) : '0;
            posy        <= v_vis ? Y_W'(v_cnt) : '0;
            active      <= h_vis && v_vis;
            hs_lvl      <= sync_level(hs_raw, H_POL);
            vs_lvl      <= sync_level(vs_raw, V_POL);
            line_start  <= h_zero;
            frame_start <= h_zero && v_zero;
            line_irq    <= h_zero && cmp_hit;
            frame_q     <= frame_q + 16'(frame_start);
            if (h_cnt == H_LAST_C) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST_C) ? '0 : v_cnt + VC_W'(1);
            end else begin
                h_cnt <= h_cnt + HC_W'(1);
            end
        end
    end

    assign pipe_in.hsync = hs_lvl;
    assign pipe_in.vsync = vs_lvl;
    assign pipe_in.de    = active;

    vga_sync_delay #(
        .DEPTH     (PIPE_DLY),
        .FLUSH_VAL (sync_bus_t'({~H_POL, ~V_POL, 1'b0}))
    ) u_sync_delay (
        .clk   (clk),
        .en    (pix_en),
        .flush (rst || !run),
        .din   (pipe_in),
        .dout  (pipe_out)
    );

    assign h_sync_o  = pipe_out.hsync;
    assign v_sync_o  = pipe_out.vsync;
    assign de_o      = pipe_out.de;
    assign frame_cnt = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing, a tiny-raster instance
// for frame-level behaviour, and an H_POL=1 / PIPE_DLY=0 instance.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // d0: defaults
    logic rst0, pe0, run0;
    logic [9:0] lc0, px0, py0;
    logic act0, hs0, vs0, de0, ls0, fs0, irq0;
    logic [15:0] fc0;
    // d1: 15 clocks/line, 10 lines/frame, PIPE_DLY=1
    logic rst1, pe1, run1;
    logic [9:0] lc1, px1, py1;
    logic act1, hs1, vs1, de1, ls1, fs1, irq1;
    logic [15:0] fc1;
    // d2: defaults with H_POL=1, PIPE_DLY=0
    logic rst2, pe2, run2;
    logic [9:0] lc2, px2, py2;
    logic act2, hs2, vs2, de2, ls2, fs2, irq2;
    logic [15:0] fc2;

    vga_timing_gen dut0 (
        .clk(clk), .rst(rst0), .pix_en(pe0), .run(run0), .line_cmp(lc0),
        .posx(px0), .posy(py0), .active(act0), .h_sync_o(hs0), .v_sync_o(vs0),
        .de_o(de0), .line_start(ls0), .frame_start(fs0), .line_irq(irq0), .frame_cnt(fc0)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIPE_DLY(1)
    ) dut1 (
        .clk(clk), .rst(rst1), .pix_en(pe1), .run(run1), .line_cmp(lc1),
        .posx(px1), .posy(py1), .active(act1), .h_sync_o(hs1), .v_sync_o(vs1),
        .de_o(de1), .line_start(ls1), .frame_start(fs1), .line_irq(irq1), .frame_cnt(fc1)
    );

    vga_timing_gen #(
        .H_POL(1'b1), .PIPE_DLY(0)
    ) dut2 (
        .clk(clk), .rst(rst2), .pix_en(pe2), .run(run2), .line_cmp(lc2),
        .posx(px2), .posy(py2), .active(act2), .h_sync_o(hs2), .v_sync_o(vs2),
        .de_o(de2), .line_start(ls2), .frame_start(fs2), .line_irq(irq2), .frame_cnt(fc2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ls0(input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (ls0) begin found = 1'b1; break; end
        end
    endtask

    task automatic wait_fs1(input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (fs1) begin found = 1'b1; break; end
        end
    endtask

    task automatic wait_ls2(input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (ls2) begin found = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        pe0 = 1'b0; pe1 = 1'b1; pe2 = 1'b1;
        run0 = 1'b1; run1 = 1'b1; run2 = 1'b1;
        lc0 = 10'd600; lc1 = 10'd3; lc2 = 10'd0;
        repeat (3) tick();
        n_tests++; if (px0 !== 10'd0 || py0 !== 10'd0) begin n_fail++; $display("FAIL reset_pos: got %0d,%0d want 0,0", px0, py0); end
        n_tests++; if ({act0, de0, ls0, fs0, irq0} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {act0, de0, ls0, fs0, irq0}); end
        n_tests++; if (fc0 !== 16'd0) begin n_fail++; $display("FAIL reset_fc0: got %0d want 0", fc0); end
        n_tests++; if ({hs0, vs0} !== 2'b11) begin n_fail++; $display("FAIL reset_sync0: got %b want 11", {hs0, vs0}); end
        n_tests++; if ({hs2, vs2} !== 2'b01) begin n_fail++; $display("FAIL reset_sync2: got %b want 01", {hs2, vs2}); end
        n_tests++; if (fc1 !== 16'd0) begin n_fail++; $display("FAIL reset_fc1: got %0d want 0", fc1); end
    endtask

    task automatic test_release();
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; pe0 = 1'b1;
        tick();
        n_tests++; if ({fs0, ls0, act0} !== 3'b111) begin n_fail++; $display("FAIL rel_pulses: got %b want 111", {fs0, ls0, act0}); end
        n_tests++; if (px0 !== 10'd0 || py0 !== 10'd0) begin n_fail++; $display("FAIL rel_pos: got %0d,%0d want 0,0", px0, py0); end
        n_tests++; if (fc0 !== 16'd0) begin n_fail++; $display("FAIL rel_fc: got %0d want 0", fc0); end
        n_tests++; if ({hs0, vs0, de0} !== 3'b110) begin n_fail++; $display("FAIL rel_sync0: got %b want 110", {hs0, vs0, de0}); end
        n_tests++; if ({de2, fs2, irq2} !== 3'b111) begin n_fail++; $display("FAIL rel_d2: got %b want 111", {de2, fs2, irq2}); end
        tick();
        n_tests++; if ({fs0, ls0} !== 2'b00 || px0 !== 10'd1) begin n_fail++; $display("FAIL rel_next: got fs=%b ls=%b px=%0d want 0 0 1", fs0, ls0, px0); end
        n_tests++; if (fc0 !== 16'd1) begin n_fail++; $display("FAIL rel_fc_inc: got %0d want 1", fc0); end
        n_tests++; if (de0 !== 1'b0) begin n_fail++; $display("FAIL rel_de_early: got %b want 0", de0); end
        tick();
        n_tests++; if (de0 !== 1'b1) begin n_fail++; $display("FAIL rel_de_dly: got %b want 1", de0); end
    endtask

    task automatic test_hline();
        bit found;
        int lo_cnt = 0, lo_first = -1, act_cnt = 0, de_cnt = 0, de_first = -1, extra_ls = 0;
        logic [9:0] px_639 = '0, px_640 = '1, py_0 = '1;
        wait_ls0(2000, found);
        n_tests++; if (!found) begin n_fail++; $display("FAIL hline_wait: got timeout want line_start"); end
        for (int k = 0; k < 800; k++) begin
            if (!hs0) begin if (lo_cnt == 0) lo_first = k; lo_cnt++; end
            if (de0) begin if (de_cnt == 0) de_first = k; de_cnt++; end
            if (act0) act_cnt++;
            if (k > 0 && ls0) extra_ls++;
            if (k == 0) py_0 = py0;
            if (k == 639) px_639 = px0;
            if (k == 640) px_640 = px0;
            tick();
        end
        n_tests++; if (ls0 !== 1'b1) begin n_fail++; $display("FAIL hline_period: got ls=%b at 800 want 1", ls0); end
        n_tests++; if (extra_ls != 0) begin n_fail++; $display("FAIL hline_extra_ls: got %0d want 0", extra_ls); end
        n_tests++; if (lo_cnt != 96) begin n_fail++; $display("FAIL hsync_width: got %0d want 96", lo_cnt); end
        n_tests++; if (lo_first != 658) begin n_fail++; $display("FAIL hsync_start: got %0d want 658", lo_first); end
        n_tests++; if (act_cnt != 640) begin n_fail++; $display("FAIL hline_active: got %0d want 640", act_cnt); end
        n_tests++; if (de_cnt != 640 || de_first != 2) begin n_fail++; $display("FAIL hline_de: got %0d from %0d want 640 from 2", de_cnt, de_first); end
        n_tests++; if (px_639 !== 10'd639 || px_640 !== 10'd0) begin n_fail++; $display("FAIL hline_posx: got %0d,%0d want 639,0", px_639, px_640); end
        n_tests++; if (py_0 !== 10'd1) begin n_fail++; $display("FAIL hline_posy: got %0d want 1", py_0); end
    endtask

    task automatic test_pix_en_toggle();
        logic prev = 1'b1;
        int rises = 0, rise1 = -1, rise2 = -1, highs = 0, fs_hi = 0, irq_hi = 0;
        for (int t = 1; t <= 3300; t++) begin
            pe0 = ~pe0;
            tick();
            if (ls0 && !prev) begin
                rises++;
                if (rises == 1) rise1 = t;
                if (rises == 2) rise2 = t;
            end
            if (t >= 2 && ls0) highs++;
            if (fs0) fs_hi++;
            if (irq0) irq_hi++;
            prev = ls0;
        end
        pe0 = 1'b1;
        n_tests++; if (rises != 2) begin n_fail++; $display("FAIL toggle_rises: got %0d want 2", rises); end
        n_tests++; if (rise1 != 1600 || rise2 != 3200) begin n_fail++; $display("FAIL toggle_period: got %0d,%0d want 1600,3200", rise1, rise2); end
        n_tests++; if (highs != 4) begin n_fail++; $display("FAIL toggle_width: got %0d want 4", highs); end
        n_tests++; if (fs_hi != 0 || irq_hi != 0) begin n_fail++; $display("FAIL toggle_spurious: got fs=%0d irq=%0d want 0 0", fs_hi, irq_hi); end
    endtask

    task automatic test_mid_reset();
        bit found;
        wait_ls0(2000, found);
        n_tests++; if (!found) begin n_fail++; $display("FAIL midrst_wait: got timeout want line_start"); end
        repeat (300) tick();
        n_tests++; if (px0 !== 10'd300) begin n_fail++; $display("FAIL midrst_pre_posx: got %0d want 300", px0); end
        n_tests++; if (fc0 !== 16'd1) begin n_fail++; $display("FAIL midrst_pre_fc: got %0d want 1", fc0); end
        rst0 = 1'b1;
        tick();
        n_tests++; if (px0 !== 10'd0 || fc0 !== 16'd0 || hs0 !== 1'b1) begin n_fail++; $display("FAIL midrst_during: got px=%0d fc=%0d hs=%b want 0 0 1", px0, fc0, hs0); end
        rst0 = 1'b0;
        tick();
        n_tests++; if ({fs0, ls0} !== 2'b11) begin n_fail++; $display("FAIL midrst_fs: got %b want 11", {fs0, ls0}); end
        n_tests++; if (px0 !== 10'd0 || py0 !== 10'd0) begin n_fail++; $display("FAIL midrst_pos: got %0d,%0d want 0,0", px0, py0); end
        n_tests++; if ({hs0, vs0} !== 2'b11 || fc0 !== 16'd0) begin n_fail++; $display("FAIL midrst_sync_fc: got %b fc=%0d want 11 fc=0", {hs0, vs0}, fc0); end
    endtask

    task automatic test_frame();
        bit found;
        int fs_cnt = 0, fs_t2 = -1, ls_cnt = 0, irq_cnt = 0, irq_t1 = -1, irq_nols = 0;
        int vlo_cnt = 0, vlo_first = -1, hlo_cnt = 0, de_cnt = 0;
        logic [9:0] py_78 = '1, py_90 = '1;
        logic act_90 = 1'b1;
        wait_fs1(400, found);
        n_tests++; if (!found) begin n_fail++; $display("FAIL frame_wait: got timeout want frame_start"); end
        for (int t = 0; t < 300; t++) begin
            if (fs1) begin fs_cnt++; if (fs_cnt == 2) fs_t2 = t; end
            if (ls1) ls_cnt++;
            if (irq1) begin irq_cnt++; if (irq_t1 < 0) irq_t1 = t; if (!ls1) irq_nols++; end
            if (!vs1) begin if (vlo_cnt == 0) vlo_first = t; vlo_cnt++; end
            if (!hs1) hlo_cnt++;
            if (de1) de_cnt++;
            if (t == 78) py_78 = py1;
            if (t == 90) begin py_90 = py1; act_90 = act1; end
            tick();
        end
        n_tests++; if (fs_cnt != 2 || fs_t2 != 150) begin n_fail++; $display("FAIL frame_period: got %0d pulses, 2nd at %0d want 2 at 150", fs_cnt, fs_t2); end
        n_tests++; if (ls_cnt != 20) begin n_fail++; $display("FAIL frame_lines: got %0d want 20", ls_cnt); end
        n_tests++; if (irq_cnt != 2 || irq_t1 != 45 || irq_nols != 0) begin n_fail++; $display("FAIL frame_irq: got %0d first %0d unaligned %0d want 2 45 0", irq_cnt, irq_t1, irq_nols); end
        n_tests++; if (vlo_cnt != 60 || vlo_first != 106) begin n_fail++; $display("FAIL frame_vsync: got %0d from %0d want 60 from 106", vlo_cnt, vlo_first); end
        n_tests++; if (hlo_cnt != 60) begin n_fail++; $display("FAIL frame_hsync: got %0d want 60", hlo_cnt); end
        n_tests++; if (de_cnt != 96) begin n_fail++; $display("FAIL frame_de: got %0d want 96", de_cnt); end
        n_tests++; if (py_78 !== 10'd5 || py_90 !== 10'd0 || act_90 !== 1'b0) begin n_fail++; $display("FAIL frame_posy: got %0d,%0d act=%b want 5,0 act=0", py_78, py_90, act_90); end
    endtask

    task automatic test_line_irq_range();
        bit found;
        int irq_cnt = 0, irq_t1 = -1;
        wait_fs1(400, found);
        n_tests++; if (!found) begin n_fail++; $display("FAIL irqr_wait: got timeout want frame_start"); end
        for (int t = 0; t < 500; t++) begin
            if (irq1) begin irq_cnt++; if (irq_t1 < 0) irq_t1 = t; end
            if (t == 0) lc1 = 10'd10;
            if (t == 150) lc1 = 10'd600;
            if (t == 335) lc1 = 10'd2;
            tick();
        end
        n_tests++; if (irq_cnt != 1) begin n_fail++; $display("FAIL irqr_count: got %0d want 1", irq_cnt); end
        n_tests++; if (irq_t1 != 480) begin n_fail++; $display("FAIL irqr_when: got %0d want 480", irq_t1); end
    endtask

    task automatic test_pol_nodelay();
        bit found;
        int hi_cnt = 0, hi_first = -1, de_cnt = 0, de_diff = 0;
        wait_ls2(1000, found);
        n_tests++; if (!found) begin n_fail++; $display("FAIL pol_wait: got timeout want line_start"); end
        for (int k = 0; k < 800; k++) begin
            if (hs2) begin if (hi_cnt == 0) hi_first = k; hi_cnt++; end
            if (de2) de_cnt++;
            if (de2 !== act2) de_diff++;
            tick();
        end
        n_tests++; if (hi_cnt != 96 || hi_first != 656) begin n_fail++; $display("FAIL pol_hsync: got %0d from %0d want 96 from 656", hi_cnt, hi_first); end
        n_tests++; if (de_cnt != 640 || de_diff != 0) begin n_fail++; $display("FAIL pol_de: got %0d, %0d misaligned want 640, 0", de_cnt, de_diff); end
    endtask

    task automatic test_frame_cnt_wrap();
        bit found;
        pe1 = 1'b0;
        tick();
        force dut1.frame_q = 16'hFFFF;
        tick();
        release dut1.frame_q;
        tick();
        n_tests++; if (fc1 !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want ffff", fc1); end
        pe1 = 1'b1;
        wait_fs1(400, found);
        n_tests++; if (!found) begin n_fail++; $display("FAIL wrap_wait: got timeout want frame_start"); end
        n_tests++; if (fc1 !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_at_fs: got %h want ffff", fc1); end
        tick();
        n_tests++; if (fc1 !== 16'h0000) begin n_fail++; $display("FAIL wrap_after: got %h want 0000", fc1); end
    endtask

    task automatic test_run_off();
        repeat (20) tick();
        run1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++; if ({hs1, vs1, de1, act1} !== 4'b1100) begin n_fail++; $display("FAIL runoff_sync[%0d]: got %b want 1100", i, {hs1, vs1, de1, act1}); end
            n_tests++; if (fc1 !== 16'd0) begin n_fail++; $display("FAIL runoff_fc[%0d]: got %0d want 0", i, fc1); end
        end
        run1 = 1'b1;
        tick();
        n_tests++; if (fs1 !== 1'b1 || px1 !== 10'd0 || fc1 !== 16'd0) begin n_fail++; $display("FAIL runon_first: got fs=%b px=%0d fc=%0d want 1 0 0", fs1, px1, fc1); end
        tick();
        n_tests++; if (fc1 !== 16'd1) begin n_fail++; $display("FAIL runon_fc: got %0d want 1", fc1); end
    endtask

    initial begin
        test_reset();
        test_release();
        test_hline();
        test_pix_en_toggle();
        test_mid_reset();
        test_frame();
        test_line_irq_range();
        test_pol_nodelay();
        test_frame_cnt_wrap();
        test_run_off();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
